// File: rtl/seven_segment_monitor.sv
// Receive-side decoder for a multiplexed active-low seven-segment bus: rebuilds the four digits,
// strobes on a full frame and flags illegal patterns. Define SEG_MONITOR_HEX_EN to accept A-F.
module seven_segment_monitor #(
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode_sel,
    input  logic [6:0]  led_out,
    input  logic        err_clr,
    output logic [15:0] digits,
    output logic [3:0]  digit_valid,
    output logic        frame_pulse,
    output logic        seg_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_HELD   = 2'd2;

    logic [3:0]       an_q, an_prev_q;
    logic [6:0]       seg_q, seg_prev_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       fset_q, fset_d;
    logic             pulse_q, pulse_d;
    logic             err_q, err_d;

    logic       onehot_c;
    logic [1:0] pos_c;
    logic       is_digit_c;
    logic       changed_c;
    logic       capture_c;
    logic [4:0] dec_c;

    // Pattern to {legal, value}; hex letters only when the macro is defined.
    function automatic logic [4:0] decode(input logic [6:0] pat);
        logic [4:0] r;
        r = 5'h00;
        case (pat)
            7'h01: r = {1'b1, 4'h0};
            7'h4F: r = {1'b1, 4'h1};
            7'h12: r = {1'b1, 4'h2};
            7'h06: r = {1'b1, 4'h3};
            7'h4C: r = {1'b1, 4'h4};
            7'h24: r = {1'b1, 4'h5};
            7'h20: r = {1'b1, 4'h6};
            7'h0F: r = {1'b1, 4'h7};
            7'h00: r = {1'b1, 4'h8};
            7'h04: r = {1'b1, 4'h9};
`ifdef SEG_MONITOR_HEX_EN
            7'h08: r = {1'b1, 4'hA};
            7'h60: r = {1'b1, 4'hB};
            7'h31: r = {1'b1, 4'hC};
            7'h42: r = {1'b1, 4'hD};
            7'h30: r = {1'b1, 4'hE};
            7'h38: r = {1'b1, 4'hF};
`else
`endif
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // Classify the registered sample.
    always_comb begin
        onehot_c = 1'b1;
        pos_c    = 2'd0;
        case (an_q)
            4'b1110: pos_c = 2'd0;
            4'b1101: pos_c = 2'd1;
            4'b1011: pos_c = 2'd2;
            4'b0111: pos_c = 2'd3;
            default: onehot_c = 1'b0;
        endcase
    end

    assign is_digit_c = onehot_c && (seg_q != 7'h7F);
    assign changed_c  = (an_q != an_prev_q) || (seg_q != seg_prev_q);
    assign dec_c      = decode(seg_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            an_prev_q  <= 4'hF;
            seg_prev_q <= 7'h7F;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            digits_q   <= 16'h0000;
            valid_q    <= 4'b0000;
            fset_q     <= 4'b0000;
            pulse_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            an_q       <= anode_sel;
            seg_q      <= led_out;
            an_prev_q  <= an_q;
            seg_prev_q <= seg_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            digits_q   <= digits_d;
            valid_q    <= valid_d;
            fset_q     <= fset_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
        end
    end

    // Dwell tracking: capture fires on the edge the count reaches STABLE_CYCLES.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_digit_c) begin
                    cnt_d   = CNT_ONE;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = '0;
                end
            end
            ST_SETTLE, ST_HELD: begin
                if (changed_c) begin
                    if (is_digit_c) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_SETTLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else if (state_q == ST_SETTLE && cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_d == CNT_MAX) begin
                        capture_c = 1'b1;
                        state_d   = ST_HELD;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture, frame tracking and sticky error.
    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        fset_d   = fset_q;
        pulse_d  = 1'b0;
        err_d    = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (capture_c) begin
            if (dec_c[4]) begin
                digits_d[{pos_c, 2'b00} +: 4] = dec_c[3:0];
                valid_d[pos_c]                = 1'b1;
                fset_d[pos_c]                 = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
        if (fset_d == 4'hF) begin
            pulse_d = 1'b1;
            fset_d  = 4'h0;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_pulse = pulse_q;
    assign seg_err     = err_q;

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Directed bench for seven_segment_monitor: table of 20-cycle dwells plus hand sequences for
// exact latency, glitches, hex legality, error clear and reset mid-dwell.
module tb_seven_segment_monitor;

    logic        clk;
    logic        reset;
    logic [3:0]  anode_sel;
    logic [6:0]  led_out;
    logic        err_clr;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        frame_pulse;
    logic        seg_err;

    int          n_tests;
    int          n_fail;
    int          pulse_cnt;
    logic [15:0] pulse_digits;

    localparam logic [3:0] D0 = 4'b1110;
    localparam logic [3:0] D1 = 4'b1101;
    localparam logic [3:0] D2 = 4'b1011;
    localparam logic [3:0] D3 = 4'b0111;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        logic [15:0] dig;
        logic [3:0]  val;
        int          pulses;
        logic [15:0] pdig;
    } vec_t;

    vec_t tbl[15];

    seven_segment_monitor #(.STABLE_CYCLES(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .anode_sel   (anode_sel),
        .led_out     (led_out),
        .err_clr     (err_clr),
        .digits      (digits),
        .digit_valid (digit_valid),
        .frame_pulse (frame_pulse),
        .seg_err     (seg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count frame strobes and remember the digits shown with each one.
    initial begin
        pulse_cnt    = 0;
        pulse_digits = 16'h0000;
    end
    always @(negedge clk) begin
        if (frame_pulse === 1'b1) begin
            pulse_cnt    = pulse_cnt + 1;
            pulse_digits = digits;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        anode_sel = an;
        led_out   = seg;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(4'hF, 7'h7F);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    logic [15:0] exp_dig;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        reset     = 1'b1;
        err_clr   = 1'b0;
        anode_sel = 4'hF;
        led_out   = 7'h7F;

        tbl[0]  = '{D3, 7'h01, 16'h0000, 4'b1000, 0, 16'h0000};
        tbl[1]  = '{D2, 7'h01, 16'h0000, 4'b1100, 0, 16'h0000};
        tbl[2]  = '{D1, 7'h12, 16'h0020, 4'b1110, 0, 16'h0000};
        tbl[3]  = '{D0, 7'h12, 16'h0022, 4'b1111, 1, 16'h0022};
        tbl[4]  = '{D3, 7'h01, 16'h0022, 4'b1111, 1, 16'h0022};
        tbl[5]  = '{D2, 7'h01, 16'h0022, 4'b1111, 1, 16'h0022};
        tbl[6]  = '{D1, 7'h12, 16'h0022, 4'b1111, 1, 16'h0022};
        tbl[7]  = '{D0, 7'h12, 16'h0022, 4'b1111, 2, 16'h0022};
        tbl[8]  = '{D0, 7'h4C, 16'h0024, 4'b1111, 2, 16'h0022};
        tbl[9]  = '{D2, 7'h0F, 16'h0724, 4'b1111, 2, 16'h0022};
        tbl[10] = '{D1, 7'h04, 16'h0794, 4'b1111, 2, 16'h0022};
        tbl[11] = '{D3, 7'h00, 16'h8794, 4'b1111, 3, 16'h8794};
        tbl[12] = '{D1, 7'h7F, 16'h8794, 4'b1111, 3, 16'h8794};
        tbl[13] = '{4'b0011, 7'h12, 16'h8794, 4'b1111, 3, 16'h8794};
        tbl[14] = '{D0, 7'h24, 16'h8795, 4'b1111, 3, 16'h8795 & 16'h0000 | 16'h8794};

        // Reset values, including while reset is still asserted.
        step(1);
        check("reset_digits", 32'(digits), 32'h0);
        check("reset_valid", 32'(digit_valid), 32'h0);
        check("reset_pulse", 32'(frame_pulse), 32'h0);
        check("reset_err", 32'(seg_err), 32'h0);
        reset = 1'b0;
        step(30);
        check("idle_digits", 32'(digits), 32'h0);
        check("idle_valid", 32'(digit_valid), 32'h0);
        check("idle_err", 32'(seg_err), 32'h0);
        check("idle_pulses", 32'(pulse_cnt), 32'd0);

        // Exact 16-sample dwell latency on digit 0 then digit 1.
        drive(D0, 7'h12);
        step(16);
        check("lat_before_digits", 32'(digits), 32'h0);
        check("lat_before_valid", 32'(digit_valid), 32'h0);
        drive(D1, 7'h4F);
        step(1);
        check("lat_at_digits", 32'(digits), 32'h0002);
        check("lat_at_valid", 32'(digit_valid), 32'b0001);
        step(15);
        drive(4'hF, 7'h7F);
        step(1);
        check("two_digits", 32'(digits), 32'h0012);
        check("two_valid", 32'(digit_valid), 32'b0011);
        check("two_pulses", 32'(pulse_cnt), 32'd0);

        // Frame table after a clean reset.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].an, tbl[i].seg);
            step(20);
            check($sformatf("tbl%0d_digits", i), 32'(digits), 32'(tbl[i].dig));
            check($sformatf("tbl%0d_valid", i), 32'(digit_valid), 32'(tbl[i].val));
            check($sformatf("tbl%0d_err", i), 32'(seg_err), 32'h0);
            check($sformatf("tbl%0d_pulses", i), 32'(pulse_cnt), 32'(tbl[i].pulses));
            check($sformatf("tbl%0d_pulse_digits", i), 32'(pulse_digits),
                  32'(tbl[i].pulses == 3 ? 16'h8794 : (tbl[i].pulses > 0 ? 16'h0022 : 16'h0000)));
        end

        // 15-sample dwell is ignored.
        drive(D1, 7'h20);
        step(15);
        drive(4'hF, 7'h7F);
        step(3);
        check("short_dwell_digits", 32'(digits), 32'h8795);

        // One-cycle glitch restarts the count; 16 fresh samples needed.
        drive(D2, 7'h20);
        step(10);
        drive(D2, 7'h4F);
        step(1);
        drive(D2, 7'h20);
        step(15);
        check("glitch_15_digits", 32'(digits), 32'h8795);
        step(1);
        check("glitch_16_digits", 32'(digits), 32'h8795);
        step(1);
        check("glitch_cap_digits", 32'(digits), 32'h8695);

        // Hex pattern A on digit 2.
        drive(D2, 7'h08);
        step(20);
`ifdef SEG_MONITOR_HEX_EN
        exp_dig = 16'h8A95;
        check("hex_digits", 32'(digits), 32'(exp_dig));
        check("hex_err", 32'(seg_err), 32'h0);
`else
        exp_dig = 16'h8695;
        check("hex_digits", 32'(digits), 32'(exp_dig));
        check("hex_err", 32'(seg_err), 32'h1);
`endif
        drive(4'hF, 7'h7F);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_clr", 32'(seg_err), 32'h0);

        // Error set wins over a simultaneous clear.
        drive(D3, 7'h7E);
        step(16);
        drive(4'hF, 7'h7F);
        err_clr = 1'b1;
        step(1);
        check("set_wins_err", 32'(seg_err), 32'h1);
        check("illegal_digits", 32'(digits), 32'(exp_dig));
        step(1);
        err_clr = 1'b0;
        check("clr_after_set", 32'(seg_err), 32'h0);
        check("final_pulses", 32'(pulse_cnt), 32'd3);

        // Reset at count 10 discards progress; fresh dwell after release.
        drive(D3, 7'h4F);
        step(11);
        reset = 1'b1;
        #1;
        check("midreset_digits", 32'(digits), 32'h0);
        check("midreset_valid", 32'(digit_valid), 32'h0);
        step(2);
        reset = 1'b0;
        step(16);
        check("post_reset_early", 32'(digits), 32'h0);
        step(1);
        check("post_reset_digits", 32'(digits), 32'h1000);
        check("post_reset_valid", 32'(digit_valid), 32'b1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
